ssd_scan_ctrl: RTL and testbench

Time-multiplexes four BCD digits onto the shared single-digit BCD-to-7-segment decoder and the common-anode 4-digit display of the lab board.
- Selects which nibble the decoder sees, registers the returned segment pattern, and drives the active-low digit anodes.
- Inserts a blanking guard before each digit slot to suppress ghosting.
- Snapshots the input digits once per frame so a digit never tears mid-scan.

---
 rtl/ssd_pkg.sv | 21 ++
 rtl/ssd_slot_timer.sv | 42 ++++
 rtl/ssd_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the 4-digit seven-segment scan controller.
package ssd_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  // Active-low one-hot anode enable for the digit at idx.
  function automatic logic [3:0] anode_sel(input idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot/digit timebase: counts cycles within a digit slot and steps the digit index.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  output idx_t idx,
  output logic slot_wrap,
  output logic frame_wrap,
  output logic in_blank
);

  localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam idx_t             LAST_IDX  = idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] slot_cnt_r;
  idx_t             idx_r;

  assign idx        = idx_r;
  assign slot_wrap  = (slot_cnt_r == LAST_CNT);
  assign frame_wrap = slot_wrap && (idx_r == LAST_IDX);
  assign in_blank   = (slot_cnt_r < BLANK_END);

  // Slot counter wraps every SCAN_DIV cycles and advances the digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_r <= '0;
      idx_r      <= '0;
    end else if (slot_wrap) begin
      slot_cnt_r <= '0;
      idx_r      <= idx_r + idx_t'(1);
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 4-digit common-anode display scanner with per-frame digit snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  dec_sel,
  input  logic [7:0]  dec_seg,
  output logic [7:0]  seg_out,
  output logic [3:0]  an_out,
  output logic        frame_start
);

  idx_t        idx_s;
  logic        slot_wrap_s;
  logic        frame_wrap_s;
  logic        in_blank_s;
  phase_t      phase_s;
  logic [15:0] shadow_digits_r;
  logic [3:0]  shadow_dp_r;
  logic [7:0]  next_seg_s;
  logic [3:0]  next_an_s;
  logic        unused_s;

  ssd_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx_s),
    .slot_wrap  (slot_wrap_s),
    .frame_wrap (frame_wrap_s),
    .in_blank   (in_blank_s)
  );

  // The decoder's DP position is replaced by our own dp request.
  assign unused_s = ^{slot_wrap_s, dec_seg[0]};
  assign phase_s  = in_blank_s ? PH_BLANK : PH_SHOW;

  // Shadow copy of the inputs, refreshed only at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_digits_r <= 16'h0000;
      shadow_dp_r     <= 4'b0000;
    end else if (frame_wrap_s) begin
      shadow_digits_r <= digits_in;
      shadow_dp_r     <= dp_in;
    end else begin
      shadow_digits_r <= shadow_digits_r;
      shadow_dp_r     <= shadow_dp_r;
    end
  end

  // Decoder nibble select from the shadow only.
  always_comb begin
    dec_sel = 4'h0;
    case (idx_s)
      2'd0:    dec_sel = shadow_digits_r[3:0];
      2'd1:    dec_sel = shadow_digits_r[7:4];
      2'd2:    dec_sel = shadow_digits_r[11:8];
      2'd3:    dec_sel = shadow_digits_r[15:12];
      default: dec_sel = 4'h0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] zero_run_s;
  logic [3:0] lz_blank_s;

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    zero_run_s    = 4'b0000;
    zero_run_s[3] = (shadow_digits_r[15:12] == 4'h0);
    zero_run_s[2] = zero_run_s[3] && (shadow_digits_r[11:8] == 4'h0);
    zero_run_s[1] = zero_run_s[2] && (shadow_digits_r[7:4] == 4'h0);
    zero_run_s[0] = 1'b0;
    lz_blank_s    = zero_run_s & ~shadow_dp_r;
  end
`endif

  // Next segment/anode drive for the current phase and digit.
  always_comb begin
    next_seg_s = SEG_BLANK;
    next_an_s  = ANODE_OFF;
    case (phase_s)
      PH_BLANK: begin
        next_seg_s = SEG_BLANK;
        next_an_s  = ANODE_OFF;
      end
      PH_SHOW: begin
        next_an_s = anode_sel(idx_s);
`ifdef LEADING_ZERO_BLANK_EN
        if (lz_blank_s[idx_s]) begin
          next_seg_s = SEG_BLANK;
        end else begin
          next_seg_s = {dec_seg[7:1], ~shadow_dp_r[idx_s]};
        end
`else
        next_seg_s = {dec_seg[7:1], ~shadow_dp_r[idx_s]};
`endif
      end
      default: begin
        next_seg_s = SEG_BLANK;
        next_an_s  = ANODE_OFF;
      end
    endcase
  end

  // Pin-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out     <= SEG_BLANK;
      an_out      <= ANODE_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= next_seg_s;
      an_out      <= next_an_s;
      frame_start <= frame_wrap_s;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 and a BCD decoder model.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  dec_sel;
  logic [7:0]  dec_seg;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  ssd_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .dec_sel     (dec_sel),
    .dec_seg     (dec_seg),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model: active-low {a..g, dp}, dp off, dash for non-BCD.
  function automatic logic [7:0] bcd_seg(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000001;
    endcase
    return ~{p, 1'b0};
  endfunction

  assign dec_seg = bcd_seg(dec_sel);

  function automatic logic lz_blank(input logic [15:0] dig, input logic [3:0] dp, input int i);
    logic z;
    z = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0) begin
      z = 1'b1;
      for (int j = 3; j >= i; j--) begin
        if (dig[j*4 +: 4] != 4'h0) z = 1'b0;
      end
      z = z && !dp[i];
    end
`endif
    return z;
  endfunction

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 32-cycle frame showing shadow dig/dp; optionally change inputs at edge chg_k.
  task automatic check_frame(input logic [15:0] dig, input logic [3:0] dp, input int chg_k,
                             input logic [15:0] new_dig, input logic [3:0] new_dp);
    int s;
    int i;
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [7:0] raw;
    one = 4'b0001;
    for (int k = 1; k <= 32; k++) begin
      tick();
      s = (k - 1) % 8;
      i = (k - 1) / 8;
      raw = bcd_seg(dig[i*4 +: 4]);
      if (s < 2) begin
        exp_an  = 4'b1111;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(one << i);
        exp_seg = lz_blank(dig, dp, i) ? 8'hFF : {raw[7:1], ~dp[i]};
      end
      chk("an_out", k, {4'h0, an_out}, {4'h0, exp_an});
      chk("seg_out", k, seg_out, exp_seg);
      chk("frame_start", k, {7'h0, frame_start}, {7'h0, (k == 32)});
      if (k < 32) chk("dec_sel", k, {4'h0, dec_sel}, {4'h0, dig[(k/8)*4 +: 4]});
      if (k == chg_k) begin
        digits_in = new_dig;
        dp_in     = new_dp;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    #1;
    chk("rst_seg", 0, seg_out, 8'hFF);
    chk("rst_an", 0, {4'h0, an_out}, 8'h0F);
    chk("rst_fs", 0, {7'h0, frame_start}, 8'h00);
    repeat (3) tick();
    chk("rst_seg_hold", 0, seg_out, 8'hFF);
    chk("rst_an_hold", 0, {4'h0, an_out}, 8'h0F);
    chk("rst_dec_sel", 0, {4'h0, dec_sel}, 8'h00);

    digits_in = 16'h1234;
    dp_in     = 4'b0100;
    rst       = 1'b0;

    // Frame 0 shows the cleared shadow; snapshot of 1234 at its end.
    check_frame(16'h0000, 4'b0000, 0, 16'h0000, 4'b0000);
    // Frame 1 shows 1234 with DP on digit 2; inputs change to 9876 during idx 1.
    check_frame(16'h1234, 4'b0100, 10, 16'h9876, 4'b0100);
    // Frame 2 shows 9876; inputs move to 0070 with no DP.
    check_frame(16'h9876, 4'b0100, 5, 16'h0070, 4'b0000);
    // Frame 3 shows 0070; inputs move to non-BCD ABCF.
    check_frame(16'h0070, 4'b0000, 5, 16'hABCF, 4'b0000);
    // Frame 4 shows ABCF via decoder default glyphs.
    check_frame(16'hABCF, 4'b0000, 0, 16'h0000, 4'b0000);

    // Move to slot_cnt=5, idx=2 and assert reset between clock edges.
    repeat (21) tick();
    chk("pre_rst_an", 21, {4'h0, an_out}, 8'h0B);
    chk("pre_rst_seg", 21, seg_out, {bcd_seg(4'hB) | 8'h01});
    rst = 1'b1;
    #1;
    chk("async_rst_seg", 0, seg_out, 8'hFF);
    chk("async_rst_an", 0, {4'h0, an_out}, 8'h0F);
    chk("async_rst_dec_sel", 0, {4'h0, dec_sel}, 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    // Scanning restarts at idx 0 with a cleared shadow.
    check_frame(16'h0000, 4'b0000, 0, 16'h0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
